qrbm_action_select: RTL and testbench

Action-selection sequencer that sits directly downstream of the RBM free-energy core. For a state it drives the core once per candidate action, converts each free energy F into Q = −F, and picks an action: the greedy argmax, or an epsilon-greedy random action. The result goes to the PS/DMA side through a valid/ready response port.

---
 rtl/qrbm_action_select.sv | 191 +++++++++++++++++++
 tb/tb_qrbm_action_select.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qrbm_action_select.sv
// Epsilon-greedy action selector: runs the RBM free-energy core once per action,
// turns each free energy into Q = -F and returns the chosen action over valid/ready.
module qrbm_action_select #(
    parameter int          N_STATE_BITS = 8,
    parameter int          N_ACTIONS    = 4,
    parameter int          N_VISIBLE    = N_STATE_BITS + N_ACTIONS,
    parameter int          W_WIDTH      = 16,
    parameter int          ACC_WIDTH    = 32,
    parameter int          ONE          = 256,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [N_STATE_BITS-1:0]               state_bits_i,
    input  logic [7:0]                            epsilon_i,
    output logic                                  core_start_o,
    input  logic                                  core_busy_i,
    input  logic                                  core_done_i,
    output logic signed [N_VISIBLE*W_WIDTH-1:0]   core_v_o,
    input  logic signed [ACC_WIDTH-1:0]           core_F_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [$clog2(N_ACTIONS)-1:0]          rsp_action_o,
    output logic signed [ACC_WIDTH-1:0]           rsp_q_o,
    output logic signed [ACC_WIDTH-1:0]           rsp_qmax_o,
    output logic                                  rsp_greedy_o
);

    localparam int A_BITS = $clog2(N_ACTIONS);
    localparam logic [W_WIDTH-1:0] ONE_W = W_WIDTH'(ONE);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ~ACC_MIN;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CAPTURE,
        DECIDE,
        RESP
    } state_e;

    state_e                          state_q, state_d;
    logic [N_STATE_BITS-1:0]         state_bits_q, state_bits_d;
    logic [7:0]                      eps_q, eps_d;
    logic [A_BITS-1:0]               act_idx_q, act_idx_d;
    logic signed [ACC_WIDTH-1:0]     q_mem_q [N_ACTIONS];
    logic signed [ACC_WIDTH-1:0]     q_mem_d [N_ACTIONS];
    logic signed [ACC_WIDTH-1:0]     best_q_q, best_q_d;
    logic [A_BITS-1:0]               best_idx_q, best_idx_d;
    logic [15:0]                     lfsr_q, lfsr_d;
    logic [N_VISIBLE*W_WIDTH-1:0]    core_v_q, core_v_d;
    logic [A_BITS-1:0]               rsp_action_q, rsp_action_d;
    logic signed [ACC_WIDTH-1:0]     rsp_q_q, rsp_q_d;
    logic signed [ACC_WIDTH-1:0]     rsp_qmax_q, rsp_qmax_d;
    logic                            rsp_greedy_q, rsp_greedy_d;

    logic signed [ACC_WIDTH-1:0]     cap_q;
    logic                            explore;
    logic [A_BITS-1:0]               rand_act;
    logic [A_BITS-1:0]               chosen;

    // State bits map to ONE/0 elements, followed by the one-hot action field.
    function automatic logic [N_VISIBLE*W_WIDTH-1:0] build_v(
        input logic [N_STATE_BITS-1:0] s,
        input logic [A_BITS-1:0]       a
    );
        logic [N_VISIBLE*W_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < N_STATE_BITS; i++) begin
            if (s[i]) v[i*W_WIDTH +: W_WIDTH] = ONE_W;
        end
        for (int k = 0; k < N_ACTIONS; k++) begin
            if (A_BITS'(k) == a) v[(N_STATE_BITS+k)*W_WIDTH +: W_WIDTH] = ONE_W;
        end
        return v;
    endfunction

    // Negating the most negative F would overflow, so it clamps to the largest Q.
    assign cap_q    = (core_F_i == ACC_MIN) ? ACC_MAX : -core_F_i;
    assign explore  = (lfsr_q[7:0] < eps_q);
    assign rand_act = lfsr_q[8 +: A_BITS];
    assign chosen   = explore ? rand_act : best_idx_q;

    always_comb begin
        state_d      = state_q;
        state_bits_d = state_bits_q;
        eps_d        = eps_q;
        act_idx_d    = act_idx_q;
        q_mem_d      = q_mem_q;
        best_q_d     = best_q_q;
        best_idx_d   = best_idx_q;
        core_v_d     = core_v_q;
        rsp_action_d = rsp_action_q;
        rsp_q_d      = rsp_q_q;
        rsp_qmax_d   = rsp_qmax_q;
        rsp_greedy_d = rsp_greedy_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        core_start_o = 1'b0;
        req_ready_o  = (state_q == IDLE);
        rsp_valid_o  = (state_q == RESP);

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_bits_d = state_bits_i;
                    eps_d        = epsilon_i;
                    act_idx_d    = '0;
                    core_v_d     = build_v(state_bits_i, '0);
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!core_busy_i) begin
                    core_start_o = 1'b1;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (core_done_i) state_d = CAPTURE;
            end
            CAPTURE: begin
                q_mem_d[act_idx_q] = cap_q;
                // Strict compare keeps the lowest index on ties.
                if (act_idx_q == '0 || cap_q > best_q_q) begin
                    best_q_d   = cap_q;
                    best_idx_d = act_idx_q;
                end
                if (act_idx_q == A_BITS'(N_ACTIONS-1)) begin
                    state_d = DECIDE;
                end else begin
                    act_idx_d = act_idx_q + 1'b1;
                    core_v_d  = build_v(state_bits_q, act_idx_q + 1'b1);
                    state_d   = LAUNCH;
                end
            end
            DECIDE: begin
                rsp_action_d = chosen;
                rsp_greedy_d = explore ? (rand_act == best_idx_q) : 1'b1;
                rsp_q_d      = q_mem_q[chosen];
                rsp_qmax_d   = best_q_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            state_bits_q <= '0;
            eps_q        <= '0;
            act_idx_q    <= '0;
            for (int k = 0; k < N_ACTIONS; k++) q_mem_q[k] <= '0;
            best_q_q     <= '0;
            best_idx_q   <= '0;
            lfsr_q       <= LFSR_SEED;
            core_v_q     <= '0;
            rsp_action_q <= '0;
            rsp_q_q      <= '0;
            rsp_qmax_q   <= '0;
            rsp_greedy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            state_bits_q <= state_bits_d;
            eps_q        <= eps_d;
            act_idx_q    <= act_idx_d;
            for (int k = 0; k < N_ACTIONS; k++) q_mem_q[k] <= q_mem_d[k];
            best_q_q     <= best_q_d;
            best_idx_q   <= best_idx_d;
            lfsr_q       <= lfsr_d;
            core_v_q     <= core_v_d;
            rsp_action_q <= rsp_action_d;
            rsp_q_q      <= rsp_q_d;
            rsp_qmax_q   <= rsp_qmax_d;
            rsp_greedy_q <= rsp_greedy_d;
        end
    end

    assign core_v_o     = core_v_q;
    assign rsp_action_o = rsp_action_q;
    assign rsp_q_o      = rsp_q_q;
    assign rsp_qmax_o   = rsp_qmax_q;
    assign rsp_greedy_o = rsp_greedy_q;

endmodule

// File: tb/tb_qrbm_action_select.sv
// Bench for qrbm_action_select: behavioural free-energy core plus an epsilon-greedy
// reference model driven by directed and random requests.
module tb_qrbm_action_select;
    localparam int NS = 8;
    localparam int NA = 4;
    localparam int NV = NS + NA;
    localparam int WW = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk, rst_n;
    logic reqValid, reqReady;
    logic [NS-1:0] stateBits;
    logic [7:0] epsilon;
    logic coreStart, coreBusy, coreDone;
    logic signed [NV*WW-1:0] coreV;
    logic signed [31:0] coreF;
    logic rspValid, rspReady;
    logic [1:0] rspAction;
    logic signed [31:0] rspQ, rspQmax;
    logic rspGreedy;

    int errors = 0;
    int checks = 0;
    int coreLat = 3;
    int rem = 0;
    int startCount = 0;
    int exploreHits = 0;
    logic signed [31:0] fTable [NA];
    logic [NS-1:0] tbState;
    logic [NV*WW-1:0] vAtStart;
    logic inCapture;
    logic [15:0] mLfsr, mPrev;

    qrbm_action_select dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(reqValid), .req_ready_o(reqReady),
        .state_bits_i(stateBits), .epsilon_i(epsilon),
        .core_start_o(coreStart), .core_busy_i(coreBusy), .core_done_i(coreDone),
        .core_v_o(coreV), .core_F_i(coreF),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
        .rsp_action_o(rspAction), .rsp_q_o(rspQ), .rsp_qmax_o(rspQmax),
        .rsp_greedy_o(rspGreedy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [NV*WW-1:0] obs, input logic [NV*WW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NV*WW-1:0] expVec(input logic [NS-1:0] s, input int a);
        logic [NV*WW-1:0] v;
        v = '0;
        for (int i = 0; i < NS; i++) if (s[i]) v[i*WW +: WW] = 16'd256;
        v[(NS+a)*WW +: WW] = 16'd256;
        return v;
    endfunction

    function automatic logic [15:0] lfsrStep(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Free LFSR reference; mPrev holds the value of the previous cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mLfsr <= SEED;
            mPrev <= SEED;
        end else begin
            mPrev <= mLfsr;
            mLfsr <= lfsrStep(mLfsr);
        end
    end

    // Behavioural core: start to done takes coreLat cycles, F chosen by the one-hot action.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coreBusy <= 1'b0;
            coreDone <= 1'b0;
            coreF    <= '0;
            rem = 0;
            startCount = 0;
        end else begin
            coreDone <= 1'b0;
            if (reqValid && reqReady) startCount = 0;
            if (coreStart && coreBusy) checkOutput("start_while_busy", 1, 0);
            if (coreBusy) begin
                rem = rem - 1;
                if (rem <= 0) begin
                    coreDone <= 1'b1;
                    coreBusy <= 1'b0;
                end
            end else if (coreStart) begin
                int actSeen;
                actSeen = 0;
                for (int k = 0; k < NA; k++) if (coreV[(NS+k)*WW +: WW] != 0) actSeen = k;
                checkOutput("core_v_at_start", coreV, expVec(tbState, startCount));
                vAtStart = coreV;
                coreF <= fTable[actSeen];
                startCount = startCount + 1;
                coreBusy <= 1'b1;
                rem = coreLat - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            inCapture = 1'b0;
        end else begin
            if (inCapture) checkOutput("core_v_stable", coreV, vAtStart);
            inCapture = coreDone;
        end
    end

    task automatic computeExpected(input logic [15:0] l, input logic [7:0] eps,
                                   output int act, output logic signed [31:0] q,
                                   output logic signed [31:0] qmax, output logic greedy);
        logic signed [31:0] qs [NA];
        int best;
        for (int k = 0; k < NA; k++)
            qs[k] = (fTable[k] == 32'sh80000000) ? 32'sh7fffffff : -fTable[k];
        best = 0;
        for (int k = 1; k < NA; k++) if (qs[k] > qs[best]) best = k;
        if (int'(l[7:0]) < int'(eps)) begin
            act    = int'(l[9:8]);
            greedy = (act == best);
        end else begin
            act    = best;
            greedy = 1'b1;
        end
        q    = qs[act];
        qmax = qs[best];
    endtask

    task automatic applyStimulus(input logic [NS-1:0] s, input logic [7:0] eps, input int lat, input int holdCycles);
        int n;
        int act;
        logic signed [31:0] q, qmax;
        logic greedy;
        logic [1:0] hAct;
        logic signed [31:0] hQ, hQmax;
        logic hGreedy;
        @(negedge clk);
        n = 0;
        while (!reqReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_ready_idle", reqReady, 1);
        tbState   = s;
        coreLat   = lat;
        stateBits = s;
        epsilon   = eps;
        reqValid  = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        n = 0;
        while (!rspValid && n < 500) begin
            n++;
            @(negedge clk);
        end
        checkOutput("latency", n, NA * (lat + 2) + 1);
        if (!rspValid) return;
        computeExpected(mPrev, eps, act, q, qmax, greedy);
        checkOutput("rsp_action", rspAction, act);
        checkOutput("rsp_q", rspQ, q);
        checkOutput("rsp_qmax", rspQmax, qmax);
        checkOutput("rsp_greedy", rspGreedy, greedy);
        if (rspAction == mPrev[9:8]) exploreHits++;
        hAct = rspAction; hQ = rspQ; hQmax = rspQmax; hGreedy = rspGreedy;
        for (int c = 0; c < holdCycles; c++) begin
            @(negedge clk);
            checkOutput("hold_valid", rspValid, 1);
            checkOutput("hold_action", rspAction, hAct);
            checkOutput("hold_q", rspQ, hQ);
            checkOutput("hold_qmax", rspQmax, hQmax);
            checkOutput("hold_greedy", rspGreedy, hGreedy);
            checkOutput("hold_req_ready", reqReady, 0);
            checkOutput("hold_core_start", coreStart, 0);
        end
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        checkOutput("req_ready_after_rsp", reqReady, 1);
        checkOutput("rsp_valid_after_rsp", rspValid, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, reqReady, 1);
        checkOutput({tag, "_core_start"}, coreStart, 0);
        checkOutput({tag, "_core_v"}, coreV, 0);
        checkOutput({tag, "_rsp_valid"}, rspValid, 0);
        checkOutput({tag, "_rsp_action"}, rspAction, 0);
        checkOutput({tag, "_rsp_q"}, rspQ, 0);
        checkOutput({tag, "_rsp_qmax"}, rspQmax, 0);
        checkOutput({tag, "_rsp_greedy"}, rspGreedy, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; reqValid = 1'b0; rspReady = 1'b0;
        stateBits = '0; epsilon = '0; tbState = '0;
        for (int k = 0; k < NA; k++) fTable[k] = '0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;

        // Greedy with a tie between actions 1 and 3.
        fTable[0] = 100; fTable[1] = -300; fTable[2] = 50; fTable[3] = -300;
        applyStimulus(8'h3C, 8'd0, 3, 0);

        // Most negative F saturates to the largest Q.
        fTable[0] = 0; fTable[1] = 0; fTable[2] = 32'sh80000000; fTable[3] = 5;
        applyStimulus(8'h00, 8'd0, 2, 0);

        // Visible vector pattern, with 10 cycles of response backpressure.
        fTable[0] = 7; fTable[1] = -9; fTable[2] = 3; fTable[3] = 1;
        applyStimulus(8'hA5, 8'd0, 4, 10);

        // Random requests, ties and saturation mixed in.
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < NA; k++) begin
                case ($urandom_range(0, 3))
                    0: fTable[k] = $urandom;
                    1: fTable[k] = $urandom_range(0, 3) * 100 - 150;
                    2: fTable[k] = 32'sh80000000;
                    default: fTable[k] = $urandom_range(0, 2000) - 1000;
                endcase
            end
            applyStimulus(NS'($urandom), 8'($urandom), $urandom_range(2, 4), $urandom_range(0, 3));
        end

        // Reset during WAIT of action 2, then a clean request.
        fTable[0] = 10; fTable[1] = 20; fTable[2] = 30; fTable[3] = 40;
        @(negedge clk);
        tbState = 8'h5A; coreLat = 4; stateBits = 8'h5A; epsilon = 8'd0; reqValid = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        n = 0;
        while (startCount < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_action2", startCount, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_reset_no_rsp", rspValid, 0);
            checkOutput("post_reset_req_ready", reqReady, 1);
        end
        applyStimulus(8'h5A, 8'd0, 3, 0);

        // Exploration rate with epsilon=255 and a unique best at action 0.
        exploreHits = 0;
        for (int r = 0; r < 1024; r++) begin
            int base;
            base = $urandom_range(0, 100000) - 50000;
            for (int k = 0; k < NA; k++) fTable[k] = base + k * 100 + $urandom_range(0, 50);
            applyStimulus(NS'($urandom), 8'd255, 2, 0);
        end
        checkOutput("explore_rate", (exploreHits >= 900), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
